// File: rtl/step_ctrl_pkg.sv
// ============================================================================
// Module : step_ctrl_pkg
// Brief  : Opcode, FSM state and ALU-select encodings for step_control_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package step_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_JMP   = 3'b101,
        OP_BRZ   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [1:0] C_ALU_ADD = 2'b00;
    localparam logic [1:0] C_ALU_SUB = 2'b01;
    localparam logic [1:0] C_ALU_AND = 2'b10;

    function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decoder.sv
// ============================================================================
// Module : ctrl_decoder
// Brief  : Combinational IR decode; strobes qualified by the EXEC state.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decoder
    import step_ctrl_pkg::*;
#(
    parameter int IW    = 12,
    parameter int RF_AW = 3,
    parameter int D_AW  = 4
) (
    input  logic [IW-1:0]    ir,
    input  logic             is_exec,
    output logic [D_AW-1:0]  d_addr,
    output logic             d_rd,
    output logic             d_wr,
    output logic [RF_AW-1:0] rf_addr1,
    output logic [RF_AW-1:0] rf_addr2,
    output logic [RF_AW-1:0] rf_waddr,
    output logic             wr_en,
    output logic             rf_src_mem,
    output logic [1:0]       alu_sel
);

    opcode_e          w_op;
    logic [RF_AW-1:0] w_dst;
    logic [RF_AW-1:0] w_s1;
    logic [RF_AW-1:0] w_s2;

    assign w_op  = opcode_e'(ir[IW-1 -: 3]);
    assign w_dst = ir[IW-4 -: RF_AW];
    assign w_s1  = ir[2*RF_AW-1:RF_AW];
    assign w_s2  = ir[RF_AW-1:0];

    always_comb begin
        d_addr     = ir[D_AW-1:0];
        rf_waddr   = w_dst;
        rf_addr1   = w_s1;
        rf_addr2   = w_s2;
        alu_sel    = C_ALU_ADD;
        d_rd       = 1'b0;
        d_wr       = 1'b0;
        wr_en      = 1'b0;
        rf_src_mem = 1'b0;

        case (w_op)
            OP_LOAD: begin
                d_rd       = is_exec;
                wr_en      = is_exec;
                rf_src_mem = is_exec;
            end
            OP_STORE: begin
                // STORE reads the register named in the dst field.
                d_wr     = is_exec;
                rf_addr1 = w_dst;
            end
            OP_ADD: begin
                wr_en   = is_exec;
                alu_sel = C_ALU_ADD;
            end
            OP_SUB: begin
                wr_en   = is_exec;
                alu_sel = C_ALU_SUB;
            end
            OP_AND: begin
                wr_en   = is_exec;
                alu_sel = C_ALU_AND;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/step_control_unit.sv
// ============================================================================
// Module : step_control_unit
// Brief  : Single-step / free-run sequencer: PC, IR and IDLE/FETCH/EXEC/HALT FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_control_unit
    import step_ctrl_pkg::*;
#(
    parameter int IW    = 12,
    parameter int PC_W  = 4,
    parameter int RF_AW = 3,
    parameter int D_AW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             ext_step,
    input  logic             switch_en,
    input  logic [IW-1:0]    switch,
    input  logic             run,
    input  logic             zero_flag,
    output logic [PC_W-1:0]  im_addr,
    input  logic [IW-1:0]    im_data,
    output logic [D_AW-1:0]  d_addr,
    output logic             d_rd,
    output logic             d_wr,
    output logic [RF_AW-1:0] rf_addr1,
    output logic [RF_AW-1:0] rf_addr2,
    output logic [RF_AW-1:0] rf_waddr,
    output logic             wr_en,
    output logic             rf_src_mem,
    output logic [1:0]       alu_sel,
    output logic             ext_active,
    output logic             halted,
    output logic             busy
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_tgt;
    logic [IW-1:0]   r_ir;
    logic [IW-1:0]   w_ir_nxt;
    logic            r_ext_active;
    logic            w_ext_nxt;
    opcode_e         w_op;

    assign w_op     = opcode_e'(r_ir[IW-1 -: 3]);
    assign w_tgt    = r_ir[PC_W-1:0];
    assign w_pc_inc = r_pc + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_ext_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ir         <= w_ir_nxt;
            r_ext_active <= w_ext_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_ext_nxt   = r_ext_active;

        case (r_state)
            ST_IDLE: begin
                if (ext_step && switch_en) begin
                    w_ir_nxt    = switch;
                    w_ext_nxt   = 1'b1;
                    w_state_nxt = ST_EXEC;
                end else if (step || run) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_ir_nxt    = im_data;
                w_ext_nxt   = 1'b0;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_op == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                end else if (run) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end

                // Switch-sourced instructions never move the PC, branches included.
                if (!r_ext_active) begin
                    case (w_op)
                        OP_JMP:  w_pc_nxt = w_tgt;
                        OP_BRZ:  w_pc_nxt = zero_flag ? w_tgt : w_pc_inc;
                        OP_HALT: w_pc_nxt = r_pc;
                        default: w_pc_nxt = w_pc_inc;
                    endcase
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    ctrl_decoder #(
        .IW    (IW),
        .RF_AW (RF_AW),
        .D_AW  (D_AW)
    ) u_ctrl_decoder (
        .ir         (r_ir),
        .is_exec    (r_state == ST_EXEC),
        .d_addr     (d_addr),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .rf_addr1   (rf_addr1),
        .rf_addr2   (rf_addr2),
        .rf_waddr   (rf_waddr),
        .wr_en      (wr_en),
        .rf_src_mem (rf_src_mem),
        .alu_sel    (alu_sel)
    );

    assign im_addr    = r_pc;
    assign ext_active = r_ext_active;
    assign halted     = (r_state == ST_HALT);
    assign busy       = (r_state == ST_FETCH) || (r_state == ST_EXEC);

endmodule

`default_nettype wire
